// File: rtl/drfm_pkg.sv
// Shared constants, state encoding and rounding helper
// for the DRFM DAC output path.
package drfm_pkg;

  localparam int DAC_W_DEF = 14;

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_PRIME  = 2'd1;
  localparam logic [1:0] ST_STREAM = 2'd2;

  function automatic logic [15:0] midscale(input int w);
    return 16'(32'd1 << (w - 1));
  endfunction

  // Keep the top w bits, add the next bit down, clamp on carry-out
  function automatic logic [15:0] round_sat(
    input logic [31:0] x,
    input int          w
  );
    logic [31:0] top;
    logic [31:0] half;
    logic [16:0] t;
    top  = x >> (32 - w);
    half = (x >> (31 - w)) & 32'd1;
    t    = 17'(top) + 17'(half);
    if (t[w])
      return 16'((32'd1 << w) - 32'd1);
    return t[15:0];
  endfunction

endpackage

// File: rtl/iq_sample_fifo.sv
// Show-ahead synchronous FIFO for rounded I/Q pairs.
// Push while full is accepted only with a same-cycle pop.
module iq_sample_fifo #(
  parameter int W     = 28,
  parameter int DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     flush_i,
  input  logic                     push_i,
  input  logic                     pop_i,
  input  logic [W-1:0]             wdata_i,
  output logic [W-1:0]             rdata_o,
  output logic                     full_o,
  output logic                     empty_o,
  output logic [$clog2(DEPTH):0]   level_o
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_q, wr_d;
  logic [AW-1:0] rd_q, rd_d;
  logic [LW-1:0] lvl_q, lvl_d;
  logic          do_push;
  logic          do_pop;

  assign full_o  = (lvl_q == LW'(DEPTH));
  assign empty_o = (lvl_q == '0);
  assign do_pop  = pop_i & ~empty_o;
  assign do_push = push_i & (~full_o | do_pop);

  always_comb begin
    wr_d  = wr_q;
    rd_d  = rd_q;
    lvl_d = lvl_q;
    if (flush_i) begin
      wr_d  = '0;
      rd_d  = '0;
      lvl_d = '0;
    end else begin
      if (do_push) wr_d = wr_q + AW'(1);
      if (do_pop)  rd_d = rd_q + AW'(1);
      lvl_d = lvl_q + LW'(do_push) - LW'(do_pop);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_q  <= '0;
      rd_q  <= '0;
      lvl_q <= '0;
    end else begin
      wr_q  <= wr_d;
      rd_q  <= rd_d;
      lvl_q <= lvl_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push && !flush_i)
      mem[wr_q] <= wdata_i;
  end

  assign rdata_o = mem[rd_q];
  assign level_o = lvl_q;

endmodule

// File: rtl/dac_iq_formatter.sv
// Rounds shifted I/Q to DAC width, buffers and replays
// on dac_tick; midscale whenever no sample is available.
module dac_iq_formatter
  import drfm_pkg::*;
#(
  parameter int DAC_W       = DAC_W_DEF,
  parameter int DEPTH       = 16,
  parameter int PRIME_LEVEL = 8
) (
  input  logic                   M100CLK,
  input  logic                   reset_n,
  input  logic                   iq_valid,
  input  logic [31:0]            u_i_in,
  input  logic [31:0]            u_q_in,
  input  logic                   dac_en,
  input  logic                   dac_tick,
  input  logic                   clear_flags,
  output logic [DAC_W-1:0]       dac_i,
  output logic [DAC_W-1:0]       dac_q,
  output logic                   dac_valid,
  output logic [$clog2(DEPTH):0] fifo_level,
  output logic                   overflow,
  output logic                   underflow
);

  localparam int LW = $clog2(DEPTH) + 1;
  localparam logic [DAC_W-1:0] MID =
    DAC_W'(midscale(DAC_W));

  logic [DAC_W-1:0] s1_i_q, s1_i_d;
  logic [DAC_W-1:0] s1_q_q, s1_q_d;
  logic             s1_v_q;
  logic [1:0]       st_q, st_d;
  logic [DAC_W-1:0] oi_q, oi_d;
  logic [DAC_W-1:0] oq_q, oq_d;
  logic             ov_q, ov_d;
  logic             of_q, of_d;
  logic             uf_q, uf_d;
  logic             uf_set;
  logic             of_set;
  logic             push;
  logic             pop;
  logic             flush;
  logic             full;
  logic             empty;
  logic [2*DAC_W-1:0] rdata;
  logic [LW-1:0]    level;

  assign s1_i_d = iq_valid ?
    DAC_W'(round_sat(u_i_in, DAC_W)) : s1_i_q;
  assign s1_q_d = iq_valid ?
    DAC_W'(round_sat(u_q_in, DAC_W)) : s1_q_q;

  assign flush  = ~dac_en | (st_q == ST_IDLE);
  assign push   = s1_v_q & ~flush;
  assign pop    = dac_en & dac_tick & ~empty &
                  (st_q == ST_STREAM);
  assign of_set = push & full & ~pop;

  iq_sample_fifo #(
    .W     (2 * DAC_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (M100CLK),
    .rst_n   (reset_n),
    .flush_i (flush),
    .push_i  (push),
    .pop_i   (pop),
    .wdata_i ({s1_i_q, s1_q_q}),
    .rdata_o (rdata),
    .full_o  (full),
    .empty_o (empty),
    .level_o (level)
  );

  always_comb begin
    st_d   = st_q;
    oi_d   = oi_q;
    oq_d   = oq_q;
    ov_d   = 1'b0;
    uf_set = 1'b0;
    if (!dac_en) begin
      st_d = ST_IDLE;
      oi_d = MID;
      oq_d = MID;
    end else begin
      unique case (1'b1)
        (st_q == ST_IDLE): begin
          oi_d = MID;
          oq_d = MID;
          st_d = ST_PRIME;
        end
        (st_q == ST_PRIME): begin
          if (dac_tick) begin
            oi_d = MID;
            oq_d = MID;
          end
          if (level >= LW'(PRIME_LEVEL))
            st_d = ST_STREAM;
        end
        (st_q == ST_STREAM): begin
          if (dac_tick && !empty) begin
            oi_d = rdata[2*DAC_W-1:DAC_W];
            oq_d = rdata[DAC_W-1:0];
            ov_d = 1'b1;
          end else if (dac_tick) begin
            oi_d   = MID;
            oq_d   = MID;
            uf_set = 1'b1;
            st_d   = ST_PRIME;
          end
        end
        default: st_d = ST_IDLE;
      endcase
    end
  end

  // Set wins over a same-cycle clear
  assign of_d = (of_q & ~clear_flags) | of_set;
  assign uf_d = (uf_q & ~clear_flags) | uf_set;

  always_ff @(posedge M100CLK or negedge reset_n) begin
    if (!reset_n) begin
      s1_i_q <= '0;
      s1_q_q <= '0;
      s1_v_q <= 1'b0;
      st_q   <= ST_IDLE;
      oi_q   <= MID;
      oq_q   <= MID;
      ov_q   <= 1'b0;
      of_q   <= 1'b0;
      uf_q   <= 1'b0;
    end else begin
      s1_i_q <= s1_i_d;
      s1_q_q <= s1_q_d;
      s1_v_q <= iq_valid;
      st_q   <= st_d;
      oi_q   <= oi_d;
      oq_q   <= oq_d;
      ov_q   <= ov_d;
      of_q   <= of_d;
      uf_q   <= uf_d;
    end
  end

  assign dac_i      = oi_q;
  assign dac_q      = oq_q;
  assign dac_valid  = ov_q;
  assign fifo_level = level;
  assign overflow   = of_q;
  assign underflow  = uf_q;

endmodule

// File: tb/tb_dac_iq_formatter.sv
// Directed scoreboard bench for dac_iq_formatter
// (DAC_W=14, DEPTH=16, PRIME_LEVEL=8).
module tb_dac_iq_formatter;

  logic        M100CLK = 1'b0;
  logic        reset_n = 1'b0;
  logic        iq_valid = 1'b0;
  logic [31:0] u_i_in = '0;
  logic [31:0] u_q_in = '0;
  logic        dac_en = 1'b0;
  logic        dac_tick = 1'b0;
  logic        clear_flags = 1'b0;
  logic [13:0] dac_i;
  logic [13:0] dac_q;
  logic        dac_valid;
  logic [4:0]  fifo_level;
  logic        overflow;
  logic        underflow;

  int n_assert = 0;
  int n_fail   = 0;
  logic [27:0] sb [$];

  always #5 M100CLK = ~M100CLK;

  dac_iq_formatter dut (
    .M100CLK     (M100CLK),
    .reset_n     (reset_n),
    .iq_valid    (iq_valid),
    .u_i_in      (u_i_in),
    .u_q_in      (u_q_in),
    .dac_en      (dac_en),
    .dac_tick    (dac_tick),
    .clear_flags (clear_flags),
    .dac_i       (dac_i),
    .dac_q       (dac_q),
    .dac_valid   (dac_valid),
    .fifo_level  (fifo_level),
    .overflow    (overflow),
    .underflow   (underflow)
  );

  function automatic logic [13:0] model(input logic [31:0] x);
    logic [32:0] s;
    s = ({1'b0, x} + 33'h0_0002_0000) >> 18;
    if (s > 33'd16383) return 14'h3FFF;
    return s[13:0];
  endfunction

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=0x%0h expected=0x%0h",
             tag, obs, exp);
    end
  endtask

  task automatic step();
    @(negedge M100CLK);
  endtask

  task automatic send(input logic [31:0] i,
                      input logic [31:0] q,
                      input logic        keep,
                      input logic [27:0] e);
    iq_valid = 1'b1;
    u_i_in   = i;
    u_q_in   = q;
    step();
    iq_valid = 1'b0;
    step();
    if (keep) sb.push_back(e);
  endtask

  task automatic send_r(input logic keep);
    logic [31:0] i;
    logic [31:0] q;
    i = $urandom;
    q = $urandom;
    send(i, q, keep, {model(i), model(q)});
  endtask

  task automatic check_pop();
    logic [27:0] e;
    chk("sb_nonempty", 32'(sb.size() != 0), 32'd1);
    if (sb.size() != 0) begin
      e = sb.pop_front();
      chk("dac_iq", {4'h0, dac_i, dac_q}, {4'h0, e});
    end
  endtask

  task automatic tick(input logic exp_v);
    dac_tick = 1'b1;
    step();
    dac_tick = 1'b0;
    chk("dac_valid", 32'(dac_valid), 32'(exp_v));
    if (exp_v) check_pop();
    else begin
      chk("mid_i", 32'(dac_i), 32'h2000);
      chk("mid_q", 32'(dac_q), 32'h2000);
    end
  endtask

  initial begin
    step();
    step();
    chk("rst_i", 32'(dac_i), 32'h2000);
    chk("rst_q", 32'(dac_q), 32'h2000);
    chk("rst_valid", 32'(dac_valid), 32'd0);
    chk("rst_level", 32'(fifo_level), 32'd0);
    chk("rst_of", 32'(overflow), 32'd0);
    chk("rst_uf", 32'(underflow), 32'd0);
    reset_n = 1'b1;
    step();

    dac_en = 1'b1;
    step();
    step();
    send(32'hFFFF_FFFF, 32'h0002_0000, 1'b1,
         {14'h3FFF, 14'h0001});
    send(32'h0001_FFFF, 32'h0000_0000, 1'b1,
         {14'h0000, 14'h0000});
    send(32'h8000_0000, 32'h7FFD_FFFF, 1'b1,
         {14'h2000, 14'h1FFF});
    for (int k = 0; k < 4; k++) send_r(1'b1);
    chk("prime_lvl7", 32'(fifo_level), 32'd7);
    tick(1'b0);
    send_r(1'b1);
    chk("prime_lvl8", 32'(fifo_level), 32'd8);
    step();
    step();
    for (int k = 0; k < 12; k++) begin
      send_r(1'b1);
      tick(1'b1);
    end
    for (int k = 0; k < 8; k++) tick(1'b1);
    chk("drain_lvl", 32'(fifo_level), 32'd0);
    tick(1'b0);
    chk("uf_set", 32'(underflow), 32'd1);
    send_r(1'b1);
    tick(1'b0);
    clear_flags = 1'b1;
    step();
    clear_flags = 1'b0;
    chk("uf_clr", 32'(underflow), 32'd0);

    for (int k = 0; k < 7; k++) send_r(1'b1);
    step();
    step();
    for (int k = 0; k < 5; k++) tick(1'b1);
    chk("lvl3", 32'(fifo_level), 32'd3);
    iq_valid = 1'b1;
    u_i_in   = $urandom;
    u_q_in   = $urandom;
    step();
    iq_valid = 1'b0;
    sb.push_back({model(u_i_in), model(u_q_in)});
    dac_tick = 1'b1;
    step();
    dac_tick = 1'b0;
    chk("pp_valid", 32'(dac_valid), 32'd1);
    check_pop();
    chk("pp_lvl", 32'(fifo_level), 32'd3);

    for (int k = 0; k < 3; k++) send_r(1'b1);
    chk("lvl6", 32'(fifo_level), 32'd6);
    dac_en = 1'b0;
    step();
    sb.delete();
    chk("idle_lvl", 32'(fifo_level), 32'd0);
    chk("idle_i", 32'(dac_i), 32'h2000);
    chk("idle_q", 32'(dac_q), 32'h2000);
    chk("idle_valid", 32'(dac_valid), 32'd0);
    send_r(1'b0);
    chk("idle_ign", 32'(fifo_level), 32'd0);
    chk("idle_of", 32'(overflow), 32'd0);

    dac_en = 1'b1;
    step();
    step();
    for (int k = 0; k < 16; k++) send_r(1'b1);
    chk("full_of0", 32'(overflow), 32'd0);
    send_r(1'b0);
    chk("full_lvl", 32'(fifo_level), 32'd16);
    chk("of_set", 32'(overflow), 32'd1);
    clear_flags = 1'b1;
    step();
    clear_flags = 1'b0;
    chk("of_clr", 32'(overflow), 32'd0);
    for (int k = 0; k < 16; k++) tick(1'b1);
    tick(1'b0);
    chk("uf_set2", 32'(underflow), 32'd1);

    for (int k = 0; k < 5; k++) send_r(1'b1);
    chk("pre_rst_lvl", 32'(fifo_level), 32'd5);
    #2;
    reset_n = 1'b0;
    #1;
    sb.delete();
    chk("arst_lvl", 32'(fifo_level), 32'd0);
    chk("arst_i", 32'(dac_i), 32'h2000);
    chk("arst_q", 32'(dac_q), 32'h2000);
    chk("arst_of", 32'(overflow), 32'd0);
    chk("arst_uf", 32'(underflow), 32'd0);
    step();
    reset_n = 1'b1;
    step();

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_assert, n_fail);
    $finish;
  end

endmodule
